// File: rtl/addsub_cla_pipe.sv
// Pipelined signed/unsigned add/subtract: one GW-bit carry-lookahead group resolved per stage.
// Optional macro ADDSUB_SAT_EN: final stage saturates S on signed overflow.
module addsub_cla_pipe #(
    parameter int W  = 16,
    parameter int GW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         C,
    output logic         V,
    output logic         Z,
    output logic         N
);
    localparam int NG = W / GW;

    logic                 adv;
    logic [NG-1:0]        v_in, m_in, c_in;
    logic [NG-1:0][W-1:0] a_in, b_in, s_in;
    logic [NG-1:0][W-1:0] s_d;
    logic [NG-1:0]        cout_d;
    logic                 cmsb_last;

    logic [NG-1:0]        valid_q, m_q, cout_q;
    logic [NG-1:0][W-1:0] a_q, b_q, s_q;

    logic [W-1:0]         res_d, res_q;
    logic                 v_d, z_d, n_d;
    logic                 c_q, v_q, z_q, n_q;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign adv      = !valid_q[NG-1] || out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_stage
            logic [GW-1:0] ga, gb, gp, gg;
            logic [GW:0]   gc;
            logic [W-1:0]  s_nxt;

            if (gi == 0) begin : g_src
                assign v_in[gi] = in_valid;
                assign m_in[gi] = M;
                assign c_in[gi] = M;
                assign a_in[gi] = A;
                assign b_in[gi] = B;
                assign s_in[gi] = '0;
            end else begin : g_src
                assign v_in[gi] = valid_q[gi-1];
                assign m_in[gi] = m_q[gi-1];
                assign c_in[gi] = cout_q[gi-1];
                assign a_in[gi] = a_q[gi-1];
                assign b_in[gi] = b_q[gi-1];
                assign s_in[gi] = s_q[gi-1];
            end

            assign ga = a_in[gi][gi*GW +: GW];
            assign gb = b_in[gi][gi*GW +: GW] ^ {GW{m_in[gi]}};
            assign gp = ga ^ gb;
            assign gg = ga & gb;

            // Flat sum-of-products lookahead: each carry depends only on G/P and the group carry-in.
            always_comb begin
                logic gen_acc;
                logic prop_acc;
                gen_acc = 1'b0;
                prop_acc = 1'b0;
                gc = '0;
                gc[0] = c_in[gi];
                for (int j = 0; j < GW; j++) begin
                    gen_acc  = gg[j];
                    prop_acc = gp[j];
                    for (int i = j - 1; i >= 0; i--) begin
                        gen_acc  = gen_acc | (prop_acc & gg[i]);
                        prop_acc = prop_acc & gp[i];
                    end
                    gc[j+1] = gen_acc | (prop_acc & c_in[gi]);
                end
            end

            always_comb begin
                s_nxt = s_in[gi];
                s_nxt[gi*GW +: GW] = gp ^ gc[GW-1:0];
            end

            assign s_d[gi]    = s_nxt;
            assign cout_d[gi] = gc[GW];

            if (gi == NG - 1) begin : g_last
                assign cmsb_last = gc[GW-1];
            end
        end
    endgenerate

    assign v_d = cout_d[NG-1] ^ cmsb_last;

    always_comb begin
        res_d = s_d[NG-1];
`ifdef ADDSUB_SAT_EN
        if (v_d) begin
            res_d = a_in[NG-1][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        z_d = (res_d == '0);
        n_d = res_d[W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            m_q     <= '0;
            cout_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else if (adv) begin
            valid_q <= v_in;
            m_q     <= m_in;
            cout_q  <= cout_d;
            a_q     <= a_in;
            b_q     <= b_in;
            s_q     <= s_d;
            // Result/flags only change when a real result lands, so bubbles never disturb them.
            if (v_in[NG-1]) begin
                res_q <= res_d;
                c_q   <= cout_d[NG-1];
                v_q   <= v_d;
                z_q   <= z_d;
                n_q   <= n_d;
            end
        end
    end

    assign out_valid = valid_q[NG-1];
    assign S = res_q;
    assign C = c_q;
    assign V = v_q;
    assign Z = z_q;
    assign N = n_q;
endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Bench for addsub_cla_pipe: directed, back-to-back, stall, randomized and reset-in-flight scenarios.
module tb_addsub_cla_pipe;
    localparam int W  = 16;
    localparam int GW = 4;
    localparam int NG = W / GW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, S;
    logic         M, C, V, Z, N;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } res_t;

    always #5 clk = ~clk;

    addsub_cla_pipe #(.W(W), .GW(GW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .M(M),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .C(C), .V(V), .Z(Z), .N(N)
    );

    // Reference: exact integer arithmetic, then wrap / saturate.
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        res_t r;
        int sa, sb, exact, maxp, minn;
        maxp  = (1 << (W - 1)) - 1;
        minn  = -(1 << (W - 1));
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        exact = m ? (sa - sb) : (sa + sb);
        r.v   = (exact > maxp) || (exact < minn);
        r.s   = exact[W-1:0];
        r.c   = m ? (a >= b) : ((int'(a) + int'(b)) >= (1 << W));
`ifdef ADDSUB_SAT_EN
        if (r.v) r.s = (exact > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        r.z = (r.s == '0);
        r.n = r.s[W-1];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++;
        if ({S, C, V, Z, N} !== '0) begin failures++; $display("FAIL rst_data: got S=%h CVZN=%b%b%b%b want all 0", S, C, V, Z, N); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [8] = '{16'h7FFF, 16'h0000, 16'h1234, 16'hFFFF, 16'h8000, 16'h8000, 16'h0001, 16'hABCD};
        logic [W-1:0] vb [8] = '{16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        logic [7:0]   vm = 8'b1101_0110;
        for (int i = 0; i < 8; i++) begin
            res_t e;
            int   edges;
            A = va[i]; B = vb[i]; M = vm[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL dir_ready: got %b want 1", in_ready); end
            e = ref_op(A, B, M);
            tick();
            in_valid = 1'b0;
            edges = 1;
            while (out_valid !== 1'b1 && edges < 20) begin
                tick();
                edges++;
            end
            checks++;
            if (edges != NG) begin failures++; $display("FAIL dir_latency: got %0d edges want %0d", edges, NG); end
            checks++;
            if ({S, C, V, Z, N} !== e) begin
                failures++;
                $display("FAIL dir_result: got S=%h C=%b V=%b Z=%b N=%b want S=%h C=%b V=%b Z=%b N=%b",
                         S, C, V, Z, N, e.s, e.c, e.v, e.z, e.n);
            end
            $display("txn dir %0d: A=%h B=%h M=%b -> S=%h C=%b V=%b Z=%b N=%b", i, va[i], vb[i], vm[i], S, C, V, Z, N);
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir_once: got out_valid=%b want 0", out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int e = 1; e <= 8 + NG + 1; e++) begin
            logic exp_v;
            res_t r;
            if (e <= 8) begin
                in_valid = 1'b1; A = W'(e - 1); B = 16'h0F0F; M = ((e - 1) % 2 == 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: edge %0d got %b want 1", e, in_ready); end
            tick();
            exp_v = (e >= NG) && (e < NG + 8);
            checks++;
            if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid: edge %0d got %b want %b", e, out_valid, exp_v); end
            if (exp_v) begin
                r = ref_op(W'(e - NG), 16'h0F0F, ((e - NG) % 2 == 1));
                checks++;
                if ({S, C, V, Z, N} !== r) begin
                    failures++;
                    $display("FAIL b2b_result: op %0d got S=%h CVZN=%b%b%b%b want S=%h CVZN=%b%b%b%b",
                             e - NG, S, C, V, Z, N, r.s, r.c, r.v, r.z, r.n);
                end
                $display("txn b2b op %0d: S=%h C=%b V=%b Z=%b N=%b", e - NG, S, C, V, Z, N);
            end
        end
    endtask

    task automatic test_stall();
        res_t q[$];
        res_t e, first, pend;
        out_ready = 1'b0;
        for (int j = 0; j < NG; j++) begin
            A = W'($urandom); B = W'($urandom); M = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_fill: op %0d got in_ready=%b want 1", j, in_ready); end
            q.push_back(ref_op(A, B, M));
            tick();
        end
        A = W'($urandom); B = W'($urandom); M = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        pend = ref_op(A, B, M);
        first = q[0];
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hs: cycle %0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
            end
            checks++;
            if ({S, C, V, Z, N} !== first) begin
                failures++; $display("FAIL stall_hold: cycle %0d got S=%h CVZN=%b%b%b%b want S=%h CVZN=%b%b%b%b",
                                     c, S, C, V, Z, N, first.s, first.c, first.v, first.z, first.n);
            end
            tick();
        end
        out_ready = 1'b1;
        q.push_back(pend);
        for (int c = 0; c < NG + 4; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stall_extra: got unexpected result S=%h want none", S);
                end else begin
                    e = q.pop_front();
                    if ({S, C, V, Z, N} !== e) begin
                        failures++; $display("FAIL stall_order: got S=%h CVZN=%b%b%b%b want S=%h CVZN=%b%b%b%b",
                                             S, C, V, Z, N, e.s, e.c, e.v, e.z, e.n);
                    end
                    $display("txn stall drain: S=%h C=%b V=%b Z=%b N=%b", S, C, V, Z, N);
                end
            end
            tick();
            in_valid = 1'b0;
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL stall_lost: got %0d undelivered want 0", q.size()); end
    endtask

    task automatic test_random();
        logic sv [NG];
        res_t sr [NG];
        logic adv_exp;
        for (int k = 0; k < NG; k++) begin sv[k] = 1'b0; sr[k] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (out_valid !== sv[NG-1]) begin failures++; $display("FAIL rnd_valid: cycle %0d got %b want %b", cyc, out_valid, sv[NG-1]); end
            if (sv[NG-1]) begin
                checks++;
                if ({S, C, V, Z, N} !== sr[NG-1]) begin
                    failures++; $display("FAIL rnd_result: cycle %0d got S=%h CVZN=%b%b%b%b want S=%h CVZN=%b%b%b%b",
                                         cyc, S, C, V, Z, N, sr[NG-1].s, sr[NG-1].c, sr[NG-1].v, sr[NG-1].z, sr[NG-1].n);
                end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            A = W'($urandom); B = W'($urandom); M = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            adv_exp   = !sv[NG-1] || out_ready;
            #1;
            checks++;
            if (in_ready !== adv_exp) begin failures++; $display("FAIL rnd_ready: cycle %0d got %b want %b", cyc, in_ready, adv_exp); end
            if (sv[NG-1] && out_ready) $display("txn rnd out cycle %0d: S=%h C=%b V=%b Z=%b N=%b", cyc, S, C, V, Z, N);
            if (adv_exp) begin
                for (int k = NG - 1; k > 0; k--) begin sv[k] = sv[k-1]; sr[k] = sr[k-1]; end
                sv[0] = in_valid;
                sr[0] = ref_op(A, B, M);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (NG + 1) tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_flight();
        res_t e;
        int   edges;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            A = W'($urandom); B = W'($urandom); M = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {S, C, V, Z, N} !== '0) begin
            failures++; $display("FAIL rstf_clear: got out_valid=%b S=%h CVZN=%b%b%b%b want 0 and all 0", out_valid, S, C, V, Z, N);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstf_ready: got %b want 1", in_ready); end
        tick();
        rst = 1'b0;
        A = 16'h4321; B = 16'h1111; M = 1'b1; in_valid = 1'b1;
        e = ref_op(A, B, M);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstf_accept: got in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        edges = 1;
        while (out_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != NG) begin failures++; $display("FAIL rstf_latency: got %0d edges want %0d", edges, NG); end
        checks++;
        if ({S, C, V, Z, N} !== e) begin
            failures++; $display("FAIL rstf_result: got S=%h CVZN=%b%b%b%b want S=%h CVZN=%b%b%b%b",
                                 S, C, V, Z, N, e.s, e.c, e.v, e.z, e.n);
        end
        $display("txn post-reset: S=%h C=%b V=%b Z=%b N=%b", S, C, V, Z, N);
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rstf_ghost: cycle %0d got out_valid=%b S=%h want 0", c, out_valid, S); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; M = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
